// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
//   Dual-issue fetch next-PC generator placed directly downstream of
//   branch_predictor_2bit. It holds the registered fetch-block PC, looks it
//   up in a direct-mapped BTB, and picks the BTB target (when the BTB hits
//   and the predictor says taken) or the sequential PC. Redirects from
//   execute reload the PC and insert a one-cycle fetch bubble.
//
// Optional feature macro:
//   BTB_BYPASS_EN - when defined, a BTB write that matches the current
//                   lookup (same index and tag) is forwarded to pred_hit /
//                   pred_target in the same cycle.
//
// Ports
//   clk             in   1      single clock, rising edge
//   rst             in   1      synchronous, active-high reset
//   stall           in   1      decode back-pressure; hold PC and outputs
//   predict_taken   in   1      direction prediction for fetch_pc
//   redirect_valid  in   1      execute redirect request
//   redirect_pc     in   PC_W   redirect target
//   btb_wr_en       in   1      BTB install/update
//   btb_wr_pc       in   PC_W   fetch-block PC of the resolved branch
//   btb_wr_target   in   PC_W   resolved target
//   fetch_valid     out  1      fetch_pc is a live fetch this cycle
//   fetch_pc        out  PC_W   current fetch-block PC (registered)
//   pred_hit        out  1      BTB hit for fetch_pc (combinational)
//   pred_taken_out  out  1      pred_hit & predict_taken
//   pred_target     out  PC_W   BTB target, or 0 on miss
module fetch_pc_gen #(
    parameter int              PC_W         = 32,
    parameter int              BTB_ENTRIES  = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FETCH_STRIDE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            predict_taken,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            btb_wr_en,
    input  logic [PC_W-1:0] btb_wr_pc,
    input  logic [PC_W-1:0] btb_wr_target,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken_out,
    output logic [PC_W-1:0] pred_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int OFF   = $clog2(FETCH_STRIDE);
    localparam int TAG_W = PC_W - OFF - IDX_W;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] next_pc;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
    logic [PC_W-1:0]        target_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             arr_hit;

    assign rd_idx = fetch_pc[OFF +: IDX_W];
    assign rd_tag = fetch_pc[PC_W-1 -: TAG_W];
    assign wr_idx = btb_wr_pc[OFF +: IDX_W];
    assign wr_tag = btb_wr_pc[PC_W-1 -: TAG_W];

    // The offset bits inside a fetch block never take part in the lookup.
    generate
        if (OFF > 0) begin : g_offset
            logic unused_offset_bits;
            assign unused_offset_bits = ^{fetch_pc[OFF-1:0], btb_wr_pc[OFF-1:0]};
        end
    endgenerate

    // Tag/target storage is only meaningful under a set valid bit, so the
    // raw array read is gated by valid and the target is forced to 0 on miss.
    assign arr_hit = btb_valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);

`ifdef BTB_BYPASS_EN
    logic fwd_hit;
    assign fwd_hit = btb_wr_en && (wr_idx == rd_idx) && (wr_tag == rd_tag);

    always_comb begin
        pred_hit    = arr_hit || fwd_hit;
        pred_target = '0;
        if (fwd_hit) begin
            pred_target = btb_wr_target;
        end else if (arr_hit) begin
            pred_target = target_mem[rd_idx];
        end
    end
`else
    always_comb begin
        pred_hit    = arr_hit;
        pred_target = '0;
        if (arr_hit) begin
            pred_target = target_mem[rd_idx];
        end
    end
`endif

    assign pred_taken_out = pred_hit && predict_taken;

    // Wraps modulo 2^PC_W by construction.
    assign seq_pc  = fetch_pc + PC_W'(FETCH_STRIDE);
    assign next_pc = pred_taken_out ? pred_target : seq_pc;

    // Redirect beats stall; BOOT and FLUSH always leave after one cycle
    // unless a fresh redirect arrives, which restarts the bubble.
    always_comb begin
        state_next  = state;
        pc_next     = fetch_pc;
        fetch_valid = 1'b0;
        case (state)
            BOOT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FLUSH;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FLUSH;
                end else if (!stall) begin
                    pc_next = next_pc;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FLUSH;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
        end
    end

    // Valid bits are the only BTB state that needs reset; writes proceed
    // regardless of stall or the fetch state.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (btb_wr_en) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= btb_wr_target;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        predict_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_wr_en;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken_out;
    logic [31:0] pred_target;

    fetch_pc_gen #(
        .PC_W        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (RST_PC),
        .FETCH_STRIDE(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .predict_taken (predict_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .btb_wr_en     (btb_wr_en),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_target (btb_wr_target),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pred_hit      (pred_hit),
        .pred_taken_out(pred_taken_out),
        .pred_target   (pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   tests   = 0;
    int   failed  = 0;
    bit   started = 0;
    bit   done    = 0;

    // Reference model: the fetch front end is either live or in a one-cycle
    // bubble; the BTB is a map from set number to (tag, target).
    logic [31:0] m_pc;
    bit          m_live;
    logic [31:0] m_tag [int];
    logic [31:0] m_tgt [int];

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc / 32'd8) % 32'd16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 32'd128;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, record the expected
    // outputs for this cycle, advance the model across the coming edge.
    task automatic step(input bit r, input bit s, input bit pt,
                        input bit rv, input logic [31:0] rpc,
                        input bit we, input logic [31:0] wpc, input logic [31:0] wtgt);
        exp_t e;
        int   si;
        rst            = r;
        stall          = s;
        predict_taken  = pt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        btb_wr_en      = we;
        btb_wr_pc      = wpc;
        btb_wr_target  = wtgt;

        si    = set_of(m_pc);
        e.v   = m_live;
        e.pc  = m_pc;
        e.hit = 0;
        e.tgt = 32'h0;
        if (m_tag.exists(si) && m_tag[si] == tag_of(m_pc)) begin
            e.hit = 1;
            e.tgt = m_tgt[si];
        end
`ifdef BTB_BYPASS_EN
        if (we && set_of(wpc) == si && tag_of(wpc) == tag_of(m_pc)) begin
            e.hit = 1;
            e.tgt = wtgt;
        end
`endif
        e.tk = e.hit && pt;
        q.push_back(e);
        started = 1;

        if (r) begin
            m_pc   = RST_PC;
            m_live = 0;
            m_tag.delete();
            m_tgt.delete();
        end else begin
            if (we) begin
                m_tag[set_of(wpc)] = tag_of(wpc);
                m_tgt[set_of(wpc)] = wtgt;
            end
            if (rv) begin
                m_pc   = rpc;
                m_live = 0;
            end else if (!m_live) begin
                m_live = 1;
            end else if (!s) begin
                m_pc = e.tk ? e.tgt : m_pc + 32'd8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit pt);
        for (int i = 0; i < n; i++) step(0, 0, pt, 0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] pc, input bit s);
        step(0, s, 0, 1, pc, 0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return $urandom & 32'hFFFF_FFF8;
        if (k == 1) return 32'hFFFF_FFC0 + 32'($urandom_range(0, 7)) * 32'd8;
        return 32'h100 + 32'($urandom_range(0, 63)) * 32'd8;
    endfunction

    // Monitor: one output set per cycle, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("fetch_valid", 32'(fetch_valid), 32'(e.v));
                check("fetch_pc", fetch_pc, e.pc);
                check("pred_hit", 32'(pred_hit), 32'(e.hit));
                check("pred_taken_out", 32'(pred_taken_out), 32'(e.tk));
                check("pred_target", pred_target, e.tgt);
            end else if (started && !done) begin
                tests++;
                failed++;
                $display("FAIL scoreboard_underrun: got empty queue required an entry (t=%0t)", $time);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1;
        stall          = 0;
        predict_taken  = 0;
        redirect_valid = 0;
        redirect_pc    = 0;
        btb_wr_en      = 0;
        btb_wr_pc      = 0;
        btb_wr_target  = 0;
        m_pc           = RST_PC;
        m_live         = 0;
        @(posedge clk);
        #1;

        // Reset then free-running sequential fetch from RESET_PC.
        step(1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        idle(4, 0);

        // Install 0x110 -> 0x200, run taken and not-taken.
        step(0, 0, 0, 1, 32'h100, 1, 32'h110, 32'h200);
        idle(5, 1);
        redir(32'h100, 0);
        idle(5, 0);

        // Stall for three cycles at 0x108.
        redir(32'h108, 0);
        idle(1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        idle(2, 0);

        // Redirect while stalled.
        redir(32'h400, 1);
        idle(3, 0);

        // Sequential wrap at the top of the address space.
        redir(32'hFFFF_FFF8, 0);
        idle(3, 0);

        // Write colliding with the lookup of the same entry.
        redir(32'h110, 0);
        idle(1, 1);
        step(0, 0, 1, 0, 32'h0, 1, 32'h110, 32'h300);
        idle(2, 1);

        // Reset mid-operation clears the BTB.
        step(1, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        idle(2, 1);
        redir(32'h110, 0);
        idle(3, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          r, s, pt, rv, we;
            logic [31:0] rpc, wpc, wtgt;
            r    = ($urandom_range(0, 99) == 0);
            s    = ($urandom_range(0, 3) == 0);
            pt   = $urandom_range(0, 1) == 1;
            rv   = ($urandom_range(0, 9) == 0);
            we   = ($urandom_range(0, 3) == 0);
            rpc  = rand_pc();
            wpc  = rand_pc();
            wtgt = rand_pc();
            step(r, s, pt, rv, rpc, we, wpc, wtgt);
        end
        done = 1;

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
